// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is taken through a
//   valid/ready load handshake and shifted out one bit per clock, qualified by
//   sout_valid, with sout_first marking the first bit of each word. A new word
//   may be accepted while the last bit of the current word is on sout, so
//   back-to-back words stream with no idle cycle between them.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   LSB_FIRST  0: MSB transmitted first, 1: LSB transmitted first
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high; clears all state
//   din         parallel word, sampled only on an accept edge
//   load_valid  din holds a word to send
//   load_ready  word can be accepted this cycle (combinational from state)
//   sout        serial data bit (registered)
//   sout_valid  sout carries a valid bit (registered)
//   sout_first  high with the first bit of each word (registered)
//   busy        word in progress
//
//   state | meaning
//   IDLE  | no word on sout, outputs held at 0
//   SHIFT | a word is being sent, cnt = index of the bit now on sout
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sout_nx, valid_nx, first_nx;
  logic             last_bit, accept;

  // Bit at the output end of a word, and the word moved one place toward it.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign last_bit   = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      sout       <= sout_nx;
      sout_valid <= valid_nx;
      sout_first <= first_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    sout_nx  = 1'b0;
    valid_nx = 1'b0;
    first_nx = 1'b0;

    // An accept on the last bit takes priority over returning to IDLE,
    // which is what keeps consecutive words gap-free.
    if (accept) begin
      state_nx = SHIFT;
      sout_nx  = head(din);
      shreg_nx = advance(din);
      cnt_nx   = '0;
      valid_nx = 1'b1;
      first_nx = 1'b1;
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state_nx = IDLE;
      end else begin
        sout_nx  = head(shreg);
        shreg_nx = advance(shreg);
        cnt_nx   = cnt + 1'b1;
        valid_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // dut a: WIDTH=8 MSB-first, dut b: WIDTH=8 LSB-first, dut c: WIDTH=2 MSB-first
  logic [7:0] din_a, din_b;
  logic [1:0] din_c;
  logic lv_a, lv_b, lv_c;
  logic rdy_a, so_a, sv_a, sf_a, bz_a;
  logic rdy_b, so_b, sv_b, sf_b, bz_b;
  logic rdy_c, so_c, sv_c, sf_c, bz_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .load_valid(lv_a), .load_ready(rdy_a),
    .sout(so_a), .sout_valid(sv_a), .sout_first(sf_a), .busy(bz_a));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .load_valid(lv_b), .load_ready(rdy_b),
    .sout(so_b), .sout_valid(sv_b), .sout_first(sf_b), .busy(bz_b));

  piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .din(din_c), .load_valid(lv_c), .load_ready(rdy_c),
    .sout(so_c), .sout_valid(sv_c), .sout_first(sf_c), .busy(bz_c));

  // Reference model: each word becomes a list of bits in transmit order;
  // every cycle the next bit of the list is what the link must carry.
  int          m_w[3]   = '{8, 8, 2};
  bit          m_lsb[3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] m_seq[3];
  int          m_pos[3];
  int          m_left[3];
  logic        m_bit[3], m_val[3], m_first[3];

  function automatic logic get_lv(int i);
    case (i)
      0:       return lv_a;
      1:       return lv_b;
      default: return lv_c;
    endcase
  endfunction

  function automatic logic [31:0] get_din(int i);
    case (i)
      0:       return {24'd0, din_a};
      1:       return {24'd0, din_b};
      default: return {30'd0, din_c};
    endcase
  endfunction

  // {load_ready, busy, sout_first, sout_valid, sout}
  function automatic logic [4:0] get_obs(int i);
    case (i)
      0:       return {rdy_a, bz_a, sf_a, sv_a, so_a};
      1:       return {rdy_b, bz_b, sf_b, sv_b, so_b};
      default: return {rdy_c, bz_c, sf_c, sv_c, so_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_seq[i] = '0; m_pos[i] = 0; m_left[i] = 0;
      m_bit[i] = 1'b0; m_val[i] = 1'b0; m_first[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      if (get_lv(i) && (m_left[i] == 0)) begin
        d = get_din(i);
        m_seq[i] = '0;
        for (int k = 0; k < m_w[i]; k++)
          m_seq[i][k] = m_lsb[i] ? d[k] : d[m_w[i] - 1 - k];
        m_bit[i] = m_seq[i][0]; m_val[i] = 1'b1; m_first[i] = 1'b1;
        m_pos[i] = 1; m_left[i] = m_w[i] - 1;
      end else if (m_left[i] > 0) begin
        m_bit[i] = m_seq[i][m_pos[i]]; m_val[i] = 1'b1; m_first[i] = 1'b0;
        m_pos[i]++; m_left[i]--;
      end else begin
        m_bit[i] = 1'b0; m_val[i] = 1'b0; m_first[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [4:0] obs, exp;
    for (int i = 0; i < 3; i++) begin
      exp = {(m_left[i] == 0), m_val[i], m_first[i], m_val[i], m_bit[i]};
      obs = get_obs(i);
      total++;
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s dut%0d: observed rdy/busy/first/valid/sout=%b expected=%b", tag, i, obs, exp);
      end
    end
  endtask

  task automatic check_word(string tag, logic [7:0] observed, logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a negedge: reset rises between edges and is checked before any edge.
  task automatic async_reset(string tag);
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all({tag, "_assert"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, "_held"});
    reset = 1'b0;
    #1 check_all({tag, "_release"});
    @(negedge clk);
  endtask

  logic [7:0] rx;
  logic [1:0] rx2;

  initial begin
    din_a = '0; din_b = '0; din_c = '0;
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset_init");
    reset = 1'b0;
    tick("idle_after_reset");
    tick("idle_after_reset");

    async_reset("rst_idle");

    // single word MSB-first
    din_a = 8'hA5; lv_a = 1'b1;
    tick("a5_accept");
    rx = {7'd0, so_a};
    lv_a = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick("a5_bits");
      rx = {rx[6:0], so_a};
    end
    check_word("a5_word", rx, 8'hA5);
    tick("a5_idle");

    // LSB-first, 8'h01
    din_b = 8'h01; lv_b = 1'b1;
    tick("lsb01_accept");
    rx = {so_b, 7'd0};
    lv_b = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick("lsb01_bits");
      rx = {so_b, rx[7:1]};
    end
    check_word("lsb01_word", rx, 8'h01);
    tick("lsb01_idle");

    // back-to-back A5 then 3C with load_valid held
    din_a = 8'hA5; lv_a = 1'b1;
    tick("b2b_accept1");
    rx = {7'd0, so_a};
    din_a = 8'h3C;
    for (int k = 1; k < 8; k++) begin
      tick("b2b_word1");
      rx = {rx[6:0], so_a};
    end
    check_word("b2b_word1_bits", rx, 8'hA5);
    tick("b2b_accept2");
    rx = {7'd0, so_a};
    lv_a = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick("b2b_word2");
      rx = {rx[6:0], so_a};
    end
    check_word("b2b_word2_bits", rx, 8'h3C);
    tick("b2b_idle");

    // load_valid during a word is ignored
    din_a = 8'h00; lv_a = 1'b1;
    tick("ign_accept");
    lv_a = 1'b0;
    tick("ign_bit2");
    din_a = 8'hFF; lv_a = 1'b1;
    tick("ign_pulse");
    lv_a = 1'b0;
    for (int k = 0; k < 7; k++) tick("ign_tail");

    // reset during bit 4 of A5, then a clean C3
    din_a = 8'hA5; lv_a = 1'b1;
    tick("rstmid_accept");
    lv_a = 1'b0;
    for (int k = 0; k < 3; k++) tick("rstmid_bits");
    async_reset("rst_midword");
    din_a = 8'hC3; lv_a = 1'b1;
    tick("c3_accept");
    rx = {7'd0, so_a};
    lv_a = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick("c3_bits");
      rx = {rx[6:0], so_a};
    end
    check_word("c3_word", rx, 8'hC3);
    tick("c3_idle");

    // WIDTH=2, din=2'b10
    din_c = 2'b10; lv_c = 1'b1;
    tick("w2_accept");
    rx2 = {1'b0, so_c};
    lv_c = 1'b0;
    tick("w2_bit2");
    rx2 = {rx2[0], so_c};
    check_word("w2_word", {6'd0, rx2}, 8'h02);
    tick("w2_idle");

    // randomized traffic on all three instances
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_rst");
      end else begin
        lv_a = ($urandom_range(0, 3) != 0);
        lv_b = ($urandom_range(0, 3) != 0);
        lv_c = ($urandom_range(0, 2) != 0);
        din_a = 8'($urandom);
        din_b = 8'($urandom);
        din_c = 2'($urandom);
        tick("random");
      end
    end
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    for (int k = 0; k < 10; k++) tick("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that takes a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, with a data-valid qualifier and a first-bit marker. It is the sending end of the single-bit serial link whose receiving end is a clocked D flip-flop/shift chain sampling on the rising edge. Back-to-back words stream with no idle bubble.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- din  input  WIDTH  parallel word; sampled only on an accept edge
- load_valid  input  1  din holds a word to send
- load_ready  output  1  block can accept a word this cycle (combinational from state)
- sout  output  1  serial data bit (registered)
- sout_valid  output  1  sout carries a valid bit (registered)
- sout_first  output  1  high with the first bit of each word (registered)
- busy  output  1  word in progress (state == SHIFT)

## Operation
- States: IDLE, SHIFT. Reset enters IDLE.
- Internal: shift register shreg[WIDTH-1:0], bit counter cnt of $clog2(WIDTH) bits.
- load_ready = (state == IDLE) || (state == SHIFT && cnt == WIDTH-1). It never depends on load_valid.
- Accept = load_valid && load_ready at a rising edge. On accept:
  - sout <= first bit, i.e. din[WIDTH-1] when LSB_FIRST=0, din[0] when LSB_FIRST=1.
  - shreg <= din shifted by one toward the output end.
  - cnt <= 0, sout_valid <= 1, sout_first <= 1, state <= SHIFT.
- In SHIFT without accept and cnt < WIDTH-1:
  - sout <= next bit, cnt <= cnt+1, sout_first <= 0, sout_valid stays 1.
- In SHIFT, cnt == WIDTH-1 (last bit on sout), no accept:
  - state <= IDLE, sout_valid <= 0, sout_first <= 0, sout <= 0.
- In IDLE with no accept, outputs hold 0.
- load_valid during SHIFT before the last bit is ignored. The word must be held until accepted; din is not captured early.
- Simultaneous last bit and accept: the new word's first bit follows the old word's last bit on the next cycle, and sout_valid stays high.

## Timing
- Reset values: sout=0, sout_valid=0, sout_first=0, busy=0, load_ready=1, cnt=0, shreg=0.
- Reset assertion forces these values asynchronously, including mid-word. A partially sent word is discarded and is never resumed.
- Latency: the first bit appears on sout in the cycle after the accept edge.
- Each word occupies exactly WIDTH consecutive sout_valid cycles.
- Throughput: one word per WIDTH cycles when load_valid is held continuously.
- sout_first is high for exactly 1 cycle per word.
- busy falls in the cycle after the last bit, unless a back-to-back accept occurs.

## Test plan
- Reset: assert reset mid-cycle with no clock edge -> all outputs read 0 immediately and load_ready=1; deassert -> outputs stay 0 with load_valid=0.
- Single word, WIDTH=8, LSB_FIRST=0, din=8'hA5 accepted at edge 0 -> sout = 1,0,1,0,0,1,0,1 at cycles 1..8; sout_valid=1 for cycles 1..8; sout_first=1 at cycle 1 only; idle (sout_valid=0) at cycle 9.
- LSB_FIRST=1, din=8'h01 -> sout = 1,0,0,0,0,0,0,0; load_ready=1 only in cycle 8 (last bit) and in idle.
- Back-to-back: 8'hA5 then 8'h3C with load_valid held -> 16 contiguous valid cycles; sout_first at cycles 1 and 9; second word's bits are 0,0,1,1,1,1,0,0.
- Ignored load: pulse load_valid with din=8'hFF at cycle 3 of word 8'h00 -> all 8 bits are 0, and no second word is sent.
- Reset mid-word: assert reset during bit 4 of 8'hA5 -> outputs 0 at once; after release, accept 8'hC3 -> clean 1,1,0,0,0,0,1,1 with sout_first at its first bit. Repeat the single-word case at WIDTH=2 with din=2'b10 -> sout = 1,0.
